// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction-memory port, redirect request and the decode-side handshake.
// "master" is the fetch stage; "slave" is the environment (imem, execute, decode).
interface if_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_misalign;

  modport master (
    output imem_addr, if_valid, if_pc, if_instr, if_misalign,
    input  imem_instr, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_addr, if_valid, if_pc, if_instr, if_misalign,
    output imem_instr, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register feeding a 2-entry {pc, instr} FIFO toward decode.
// Optional IF_MISALIGN_CHECK_EN: misaligned redirects raise if_misalign and halt fetch.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  if_stage_if.master  bus
);

  logic [31:0]       pc_q, pc_d;
  logic [1:0]        count_q, count_d;
  logic [1:0][31:0]  ent_pc_q, ent_pc_d;
  logic [1:0][31:0]  ent_instr_q, ent_instr_d;
  logic              pop, fetch, halt;
  logic [1:0]        lvl;

`ifdef IF_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign halt            = misalign_q;
  assign bus.if_misalign = misalign_q;
`else
  assign halt            = 1'b0;
  assign bus.if_misalign = 1'b0;
`endif

  assign pop   = (count_q != 2'd0) && bus.id_ready;
  assign fetch = !halt && ((count_q < 2'd2) || pop);
  // Slot the new entry lands in after this cycle's pop has shifted the head out.
  assign lvl   = count_q - {1'b0, pop};

  always_comb begin
    pc_d        = pc_q;
    count_d     = count_q;
    ent_pc_d    = ent_pc_q;
    ent_instr_d = ent_instr_q;
`ifdef IF_MISALIGN_CHECK_EN
    misalign_d  = misalign_q;
`endif
    if (bus.redirect_valid) begin
      count_d = 2'd0;
`ifdef IF_MISALIGN_CHECK_EN
      pc_d       = bus.redirect_pc;
      misalign_d = (bus.redirect_pc[1:0] != 2'b00);
`else
      pc_d       = bus.redirect_pc & 32'hFFFF_FFFC;
`endif
    end else begin
      if (pop) begin
        ent_pc_d[0]    = ent_pc_q[1];
        ent_instr_d[0] = ent_instr_q[1];
      end
      if (fetch) begin
        ent_pc_d[lvl[0]]    = pc_q;
        ent_instr_d[lvl[0]] = bus.imem_instr;
        pc_d                = pc_q + 32'd4;
      end
      count_d = count_q + {1'b0, fetch} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      count_q     <= 2'd0;
      ent_pc_q    <= '0;
      ent_instr_q <= {NOP_INSTR, NOP_INSTR};
`ifdef IF_MISALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      pc_q        <= pc_d;
      count_q     <= count_d;
      ent_pc_q    <= ent_pc_d;
      ent_instr_q <= ent_instr_d;
`ifdef IF_MISALIGN_CHECK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = (count_q != 2'd0);
  assign bus.if_pc     = (count_q != 2'd0) ? ent_pc_q[0]    : 32'h0;
  assign bus.if_instr  = (count_q != 2'd0) ? ent_instr_q[0] : NOP_INSTR;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, hand sequences for reset corners,
// then random traffic checked against a queue-based fetch model.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_stage_if bus();
  if_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [31:0] imem_fn(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction
  assign bus.imem_instr = imem_fn(bus.imem_addr);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched words plus the next fetch address.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  logic [31:0] mpc;
  logic        mmis;

  task automatic model_reset();
    mq.delete();
    mpc  = 32'h0;
    mmis = 1'b0;
  endtask

  task automatic model_step(input logic rv, input logic [31:0] rpc, input logic rdy);
    ent_t e;
    if (rv) begin
      mq.delete();
`ifdef IF_MISALIGN_CHECK_EN
      mpc  = rpc;
      mmis = (rpc % 4) != 0;
`else
      mpc  = rpc - (rpc % 4);
`endif
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (!mmis && mq.size() < 2) begin
        e.pc = mpc; e.instr = imem_fn(mpc);
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".valid"},    {31'b0, bus.if_valid},    {31'b0, mq.size() > 0});
    chk({tag, ".pc"},       bus.if_pc,                (mq.size() > 0) ? mq[0].pc : 32'h0);
    chk({tag, ".instr"},    bus.if_instr,             (mq.size() > 0) ? mq[0].instr : NOP);
    chk({tag, ".addr"},     bus.imem_addr,            mpc);
    chk({tag, ".misalign"}, {31'b0, bus.if_misalign}, {31'b0, mmis});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        emis;
  } vec_t;

  function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic rdy,
                              input logic ev, input logic [31:0] epc,
                              input logic [31:0] eaddr, input logic emis);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.emis = emis;
    return v;
  endfunction

  vec_t tv[18];

  initial begin
    // Each row: inputs for one edge, then expected outputs just after it.
    tv[0]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h4,         1'b0);
    tv[1]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h8,         1'b0);
    tv[2]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h8,         1'b0);
    tv[3]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h8,         1'b0);
    tv[4]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h8,         1'b0);
    tv[5]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         32'hC,         1'b0);
    tv[6]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         32'h10,        1'b0);
    tv[7]  = mk(1'b1, 32'h100,       1'b1, 1'b0, 32'h0,         32'h100,       1'b0);
    tv[8]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h100,       32'h104,       1'b0);
    tv[9]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h104,       32'h108,       1'b0);
    tv[10] = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h104,       32'h10C,       1'b0);
    tv[11] = mk(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,         32'hFFFF_FFFC, 1'b0);
    tv[12] = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,         1'b0);
    tv[13] = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h4,         1'b0);
`ifdef IF_MISALIGN_CHECK_EN
    tv[14] = mk(1'b1, 32'h102,       1'b1, 1'b0, 32'h0,         32'h102,       1'b1);
    tv[15] = mk(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h102,       1'b1);
`else
    tv[14] = mk(1'b1, 32'h102,       1'b1, 1'b0, 32'h0,         32'h100,       1'b0);
    tv[15] = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h100,       32'h104,       1'b0);
`endif
    tv[16] = mk(1'b1, 32'h200,       1'b1, 1'b0, 32'h0,         32'h200,       1'b0);
    tv[17] = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h200,       32'h204,       1'b0);

    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b0;
    #2;
    chk("rst.valid",    {31'b0, bus.if_valid},    32'h0);
    chk("rst.pc",       bus.if_pc,                32'h0);
    chk("rst.instr",    bus.if_instr,             NOP);
    chk("rst.addr",     bus.imem_addr,            32'h0);
    chk("rst.misalign", {31'b0, bus.if_misalign}, 32'h0);

    // Directed table: stall saturation, redirects, wrap, misaligned redirect.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      if (i != 0) @(negedge clk);
      bus.redirect_valid = tv[i].rv;
      bus.redirect_pc    = tv[i].rpc;
      bus.id_ready       = tv[i].rdy;
      @(posedge clk); #1;
      chk($sformatf("tv%0d.valid", i),    {31'b0, bus.if_valid},    {31'b0, tv[i].ev});
      chk($sformatf("tv%0d.pc", i),       bus.if_pc,                tv[i].ev ? tv[i].epc : 32'h0);
      chk($sformatf("tv%0d.instr", i),    bus.if_instr,             tv[i].ev ? imem_fn(tv[i].epc) : NOP);
      chk($sformatf("tv%0d.addr", i),     bus.imem_addr,            tv[i].eaddr);
      chk($sformatf("tv%0d.misalign", i), {31'b0, bus.if_misalign}, {31'b0, tv[i].emis});
    end

    // Streaming from reset with decode always ready.
    @(negedge clk);
    do_reset();
    bus.id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stream%0d.valid", k), {31'b0, bus.if_valid}, 32'h1);
      chk($sformatf("stream%0d.pc", k),    bus.if_pc,             32'(k * 4));
    end

    // Async reset while the FIFO is full, with a redirect pending.
    @(negedge clk);
    do_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("full.valid", {31'b0, bus.if_valid}, 32'h1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h400;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", {31'b0, bus.if_valid}, 32'h0);
    chk("arst.instr", bus.if_instr,          NOP);
    chk("arst.pc",    bus.if_pc,             32'h0);
    chk("arst.addr",  bus.imem_addr,         32'h0);
    @(posedge clk); #1;
    chk("arst.hold_addr", bus.imem_addr, 32'h0);

    // Random traffic against the model.
    @(negedge clk);
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic        rv, rdy;
      logic [31:0] rpc;
      if (c != 0) @(negedge clk);
      model_check($sformatf("rnd%0d", c));
      rv  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF8;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.id_ready       = rdy;
      @(posedge clk);
      model_step(rv, rpc, rdy);
    end
    @(negedge clk);
    model_check("rnd_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
